rom_read_master: RTL and testbench

ROM_READ_MASTER -- requirements
Module: rom_read_master

---
 rtl/rom_read_pkg.sv | 41 ++++
 rtl/rsp_fifo.sv | 57 +++++
 rtl/rom_read_master.sv | 160 ++++++++++++++++
 tb/tb_rom_read_master.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_read_pkg.sv
// rom_read_pkg: shared AXI width defines and common types for the ROM read master.
// The AXI define block is guarded so other blocks of the codebase can repeat it.
`ifndef ROM_READ_AXI_DEFINES
`define ROM_READ_AXI_DEFINES
`define AXI_ID_W    4
`define AXI_ADDR_W  32
`define AXI_DATA_W  32
`define AXI_LEN_W   4
`define AXI_SIZE_W  3
`define AXI_BURST_W 2
`define AXI_RESP_W  2
`endif

package rom_read_pkg;

    // Read master control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // Every ROM access is a full 32-bit word, incrementing burst
    localparam logic [`AXI_SIZE_W-1:0]  SIZE_WORD  = 3'b010;
    localparam logic [`AXI_BURST_W-1:0] BURST_INCR = 2'b01;

    // One buffered response beat: data word, error flag, last-of-burst flag
    typedef struct packed {
        logic [`AXI_DATA_W-1:0] data;
        logic                   err;
        logic                   last;
    } rsp_ent_t;

    localparam int RSP_W = $bits(rsp_ent_t);

    // Word-align a byte address (ROM is only ever read as whole words)
    function automatic logic [`AXI_ADDR_W-1:0] word_align(input logic [`AXI_ADDR_W-1:0] a);
        return a & ~(`AXI_ADDR_W'(3));
    endfunction

endpackage

// File: rtl/rsp_fifo.sv
// rsp_fifo: small first-word-fall-through buffer between the AXI R channel and
// the requester. Head entry is visible whenever the buffer is non-empty.
module rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    // DEPTH is a power of two, so the pointers wrap on their own
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // Status comes only from the registered occupancy count
    assign empty   = (count == '0);
    assign full    = (count == DEPTH_CNT);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; no reset needed because count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/rom_read_master.sv
// rom_read_master: turns one requester command (word address + beat count)
// into a single AXI INCR read burst and streams the returned words back
// through a small response buffer. Foreign-ID beats and RLAST disagreements
// are absorbed and reported on a sticky protocol_err flag.
module rom_read_master
    import rom_read_pkg::*;
#(
    parameter logic [`AXI_ID_W-1:0] MASTER_ID = 4'd0,
    parameter int                   BUF_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    resetn,       // active-high despite the name

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [`AXI_ADDR_W-1:0]  req_addr,
    input  logic [`AXI_LEN_W-1:0]   req_len,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [`AXI_DATA_W-1:0]  rsp_data,
    output logic                    rsp_last,
    output logic                    rsp_err,

    output logic [`AXI_ID_W-1:0]    ARID,
    output logic [`AXI_ADDR_W-1:0]  ARADDR,
    output logic [`AXI_LEN_W-1:0]   ARLEN,
    output logic [`AXI_SIZE_W-1:0]  ARSIZE,
    output logic [`AXI_BURST_W-1:0] ARBURST,
    output logic                    ARVALID,
    input  logic                    ARREADY,

    input  logic [`AXI_ID_W-1:0]    RID,
    input  logic [`AXI_DATA_W-1:0]  RDATA,
    input  logic [`AXI_RESP_W-1:0]  RRESP,
    input  logic                    RLAST,
    input  logic                    RVALID,
    output logic                    RREADY,

    output logic                    protocol_err
);

    state_t                  state;
    logic [`AXI_ADDR_W-1:0]  addr_q;
    logic [`AXI_LEN_W-1:0]   len_q;
    logic [`AXI_LEN_W-1:0]   beat_cnt;
    logic                    req_ready_q;
    logic                    arvalid_q;
    logic                    perr_q;

    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    r_hs;
    logic                    id_ok;
    logic                    push;
    logic                    pop;
    logic                    cnt_zero;
    logic                    last_bad;
    rsp_ent_t                push_ent;
    rsp_ent_t                head_ent;

    // R channel: accept only while collecting a burst and the buffer has room.
    // Both terms are registered, so RREADY never depends on RVALID.
    assign RREADY   = (state == ST_DATA) & ~fifo_full & ~resetn;
    assign r_hs     = RVALID & RREADY;
    assign id_ok    = (RID == MASTER_ID);
    assign push     = r_hs & id_ok;
    assign cnt_zero = (beat_cnt == '0);
    // The beat counter, not RLAST, decides where the burst ends
    assign last_bad = RLAST ^ cnt_zero;

    assign push_ent = '{data: RDATA, err: (RRESP != 2'b00), last: cnt_zero};

    rsp_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (RSP_W)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (resetn),
        .push      (push),
        .push_data (push_ent),
        .pop       (pop),
        .head      (head_ent),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Requester response side: head entry falls through
    assign rsp_valid = ~fifo_empty & ~resetn;
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_data  = head_ent.data;
    assign rsp_last  = head_ent.last;
    assign rsp_err   = head_ent.err;

    // Handshake outputs are held low for the whole reset cycle, not just after it
    assign req_ready    = req_ready_q & ~resetn;
    assign ARVALID      = arvalid_q & ~resetn;
    assign ARID         = resetn ? '0 : MASTER_ID;
    assign ARADDR       = resetn ? '0 : addr_q;
    assign ARLEN        = resetn ? '0 : len_q;
    assign ARSIZE       = SIZE_WORD;
    assign ARBURST      = BURST_INCR;
    assign protocol_err = perr_q & ~resetn;

    // Command FSM: capture request, issue AR, count R beats back down to zero
    always_ff @(posedge clk) begin
        if (resetn) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            beat_cnt    <= '0;
            req_ready_q <= 1'b1;
            arvalid_q   <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        addr_q      <= word_align(req_addr);
                        len_q       <= req_len;
                        perr_q      <= 1'b0;
                        req_ready_q <= 1'b0;
                        arvalid_q   <= 1'b1;
                        state       <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    // AR fields come straight from addr_q/len_q, stable until accepted
                    if (arvalid_q && ARREADY) begin
                        beat_cnt  <= len_q;
                        arvalid_q <= 1'b0;
                        state     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_hs) begin
                        if (!id_ok) begin
                            // Foreign beat: swallowed, counter untouched
                            perr_q <= 1'b1;
                        end else begin
                            if (last_bad) perr_q <= 1'b1;
                            if (cnt_zero) begin
                                state       <= ST_IDLE;
                                req_ready_q <= 1'b1;
                            end else begin
                                beat_cnt <= beat_cnt - `AXI_LEN_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    req_ready_q <= 1'b1;
                    arvalid_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_read_master.sv
// tb_rom_read_master: table vectors, directed corner sequences and a randomized
// run against an AXI slave / requester model. Expected responses are derived
// from the words the slave model returns for each request, in request order.
module tb_rom_read_master;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic [3:0]  req_len;
    logic        rsp_valid, rsp_ready, rsp_last, rsp_err;
    logic [31:0] rsp_data;
    logic [3:0]  ARID, ARLEN;
    logic [31:0] ARADDR;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID, ARREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST, RVALID, RREADY;
    logic        protocol_err;

    rom_read_master #(.MASTER_ID(4'd0), .BUF_DEPTH(2)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .rsp_err(rsp_err),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .protocol_err(protocol_err)
    );

    typedef struct { logic [31:0] addr; logic [3:0] len; } req_t;
    typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } beat_t;
    typedef struct { logic [31:0] data; logic err; logic last; } exp_t;
    typedef struct {
        logic [31:0] addr; logic [3:0] len; logic [1:0] resp; logic [31:0] base;
        logic [31:0] exp_araddr; logic [3:0] exp_arlen; logic exp_err; int exp_beats;
    } vec_t;

    int errors = 0;
    int checks = 0;

    req_t  req_q[$];
    req_t  ar_exp_q[$];
    beat_t r_q[$];
    exp_t  exp_q[$];

    bit auto_r, rand_ar, rv_busy, ar_seen, stall_done, expect_vld, timed_out;
    int rvalid_pct, rready_pct, ar_delay, ar_left, stall_at, stall_left;
    int got_cnt, acc_cnt, arv_cycles, rhs_cnt;
    logic [31:0] ar_snap_addr, last_ar_addr;
    logic [3:0]  ar_snap_len, last_ar_len;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        req_q.delete(); ar_exp_q.delete(); r_q.delete(); exp_q.delete();
        auto_r = 0; rand_ar = 0; rv_busy = 0; ar_seen = 0; stall_done = 0;
        expect_vld = 0; timed_out = 0;
        rvalid_pct = 100; rready_pct = 100; ar_delay = 0; ar_left = 0;
        stall_at = -1; stall_left = 0;
        got_cnt = 0; acc_cnt = 0; arv_cycles = 0; rhs_cnt = 0;
    endtask

    task automatic add_req(input logic [31:0] a, input logic [3:0] l);
        req_t r;
        r.addr = a; r.len = l;
        req_q.push_back(r);
    endtask

    task automatic add_beat(input logic [3:0] id, input logic [31:0] d, input logic [1:0] rs, input logic l);
        beat_t b;
        b.id = id; b.data = d; b.resp = rs; b.last = l;
        r_q.push_back(b);
    endtask

    task automatic add_exp(input logic [31:0] d, input logic e, input logic l);
        exp_t x;
        x.data = d; x.err = e; x.last = l;
        exp_q.push_back(x);
    endtask

    // Slave model: a correct burst of len+1 random words; the requester must
    // see the same words, err when RRESP is nonzero, last only on the final one
    task automatic gen_beats(input logic [3:0] len);
        logic [31:0] d;
        logic [1:0]  rs;
        int          r;
        for (int i = 0; i <= int'(len); i++) begin
            d  = $urandom;
            r  = int'($urandom_range(0, 7));
            rs = (r < 5) ? 2'b00 : 2'(r - 4);
            add_beat(4'd0, d, rs, i == int'(len));
            add_exp(d, rs != 2'b00, i == int'(len));
        end
    endtask

    // Cycle engine: inputs are driven and outputs sampled on the falling edge
    task automatic run(input int max_cycles, input int stop_rhs);
        int   cyc;
        req_t r;
        bit   r_hs, r_push;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (expect_vld) begin
                check("rsp_valid_latency", rsp_valid, 1);
                expect_vld = 0;
            end
            if (stop_rhs >= 0 && rhs_cnt >= stop_rhs) break;
            if (req_q.size() == 0 && r_q.size() == 0 && !rv_busy && exp_q.size() == 0 &&
                ar_exp_q.size() == 0 && req_ready && !ARVALID) break;
            if (cyc >= max_cycles) begin
                timed_out = 1;
                break;
            end
            cyc++;
            // requester command side
            req_valid = (req_q.size() > 0);
            if (req_valid) begin
                req_addr = req_q[0].addr;
                req_len  = req_q[0].len;
                if (req_ready) begin
                    r = req_q.pop_front();
                    r.addr = r.addr & 32'hFFFF_FFFC;
                    ar_exp_q.push_back(r);
                end
            end
            // AR slave
            ARREADY = 0;
            if (ARVALID) begin
                arv_cycles++;
                check("req_ready_during_ar", req_ready, 0);
                if (!ar_seen) begin
                    ar_seen = 1;
                    ar_left = rand_ar ? int'($urandom_range(0, 3)) : ar_delay;
                    ar_snap_addr = ARADDR;
                    ar_snap_len  = ARLEN;
                    check("ar_expected", ar_exp_q.size() > 0, 1);
                    if (ar_exp_q.size() > 0) begin
                        check("araddr", ARADDR, ar_exp_q[0].addr);
                        check("arlen", ARLEN, ar_exp_q[0].len);
                    end
                    check("arsize_arburst_arid", {ARSIZE, ARBURST, ARID}, {3'b010, 2'b01, 4'd0});
                end else begin
                    check("ar_stable", {ARADDR, ARLEN}, {ar_snap_addr, ar_snap_len});
                end
                if (ar_left == 0) begin
                    ARREADY = 1;
                    ar_seen = 0;
                    last_ar_addr = ARADDR;
                    last_ar_len  = ARLEN;
                    if (ar_exp_q.size() > 0) begin
                        if (auto_r) gen_beats(ar_exp_q[0].len);
                        ar_exp_q.delete(0);
                    end
                end else begin
                    ar_left--;
                end
            end
            // R slave: once RVALID is raised it holds until accepted
            if (!rv_busy) begin
                RVALID = 0;
                if (r_q.size() > 0 && int'($urandom_range(0, 99)) < rvalid_pct) begin
                    RVALID = 1;
                    RID = r_q[0].id; RDATA = r_q[0].data; RRESP = r_q[0].resp; RLAST = r_q[0].last;
                    rv_busy = 1;
                end
            end
            r_hs   = RVALID && RREADY;
            r_push = r_hs && (RID == 4'd0);
            if (r_hs) begin
                r_q.delete(0);
                rv_busy = 0;
                rhs_cnt++;
            end
            if (r_push) acc_cnt++;
            if (r_push && !rsp_valid) expect_vld = 1;
            // response consumer
            rsp_ready = (int'($urandom_range(0, 99)) < rready_pct);
            if (stall_at >= 0 && !stall_done && got_cnt == stall_at) begin
                stall_done = 1;
                stall_left = 10;
            end
            if (stall_left > 0) begin
                rsp_ready = 0;
                if (stall_left == 5) begin
                    check("rready_when_full", RREADY, 0);
                    check("buffered_beats", acc_cnt - got_cnt, 2);
                end
                stall_left--;
            end
            if (rsp_valid && rsp_ready) begin
                check("rsp_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    check("rsp_beat", {rsp_data, rsp_err, rsp_last},
                          {exp_q[0].data, exp_q[0].err, exp_q[0].last});
                    exp_q.delete(0);
                end
                got_cnt++;
            end
        end
        check("run_in_budget", timed_out, 0);
        req_valid = 0;
        ARREADY   = 0;
        rsp_ready = 0;
        if (!rv_busy) RVALID = 0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[5];
        int   total;

        vecs[0] = '{32'h0000_0106, 4'd0,  2'b00, 32'hDEAD_BEEF, 32'h0000_0104, 4'd0,  1'b0, 1};
        vecs[1] = '{32'h1234_5673, 4'd15, 2'b00, 32'h0000_1000, 32'h1234_5670, 4'd15, 1'b0, 16};
        vecs[2] = '{32'hFFFF_FFFF, 4'd3,  2'b10, 32'hA5A5_0000, 32'hFFFF_FFFC, 4'd3,  1'b1, 4};
        vecs[3] = '{32'h8000_0001, 4'd1,  2'b11, 32'h0BAD_0000, 32'h8000_0000, 4'd1,  1'b1, 2};
        vecs[4] = '{32'h0000_0000, 4'd7,  2'b01, 32'h7777_0000, 32'h0000_0000, 4'd7,  1'b1, 8};

        resetn = 1; req_valid = 0; req_addr = '0; req_len = '0; rsp_ready = 0;
        ARREADY = 0; RID = '0; RDATA = '0; RRESP = '0; RLAST = 0; RVALID = 0;
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_handshakes", {req_ready, ARVALID, RREADY, rsp_valid, protocol_err}, 5'b00000);
        check("reset_ar_fields", {ARID, ARADDR, ARLEN, ARSIZE, ARBURST}, {4'd0, 32'd0, 4'd0, 3'b010, 2'b01});
        resetn = 0;
        @(negedge clk);
        check("idle_after_reset", {req_ready, ARVALID, RREADY, rsp_valid}, 4'b1000);

        // table vectors: one request each, clean protocol, fixed RRESP per row
        for (int v = 0; v < 5; v++) begin
            clear_model();
            add_req(vecs[v].addr, vecs[v].len);
            for (int i = 0; i <= int'(vecs[v].len); i++) begin
                add_beat(4'd0, vecs[v].base + 32'(i), vecs[v].resp, i == int'(vecs[v].len));
                add_exp(vecs[v].base + 32'(i), vecs[v].exp_err, i == int'(vecs[v].len));
            end
            run(300, -1);
            check("tbl_araddr", last_ar_addr, vecs[v].exp_araddr);
            check("tbl_arlen", last_ar_len, vecs[v].exp_arlen);
            check("tbl_beats", got_cnt, vecs[v].exp_beats);
            check("tbl_perr", protocol_err, 0);
        end

        // ARREADY held off 5 cycles
        clear_model();
        auto_r = 1; ar_delay = 5;
        add_req(32'h2000_0012, 4'd2);
        run(300, -1);
        check("ar_valid_cycles", arv_cycles, 6);
        check("ar_delay_beats", got_cnt, 3);

        // 16-beat burst with the consumer stalled 10 cycles mid-burst
        clear_model();
        auto_r = 1; stall_at = 4;
        add_req(32'h3000_0000, 4'd15);
        run(400, -1);
        check("stall_beats", got_cnt, 16);
        check("stall_seen", stall_done, 1);

        // early RLAST on beat 2 plus a foreign-ID beat
        clear_model();
        add_req(32'h4000_0000, 4'd3);
        add_beat(4'd0, 32'h1111_0000, 2'b00, 1'b0);
        add_beat(4'd0, 32'h1111_0001, 2'b00, 1'b1);
        add_beat(4'd5, 32'hBAD0_BAD0, 2'b00, 1'b0);
        add_beat(4'd0, 32'h1111_0002, 2'b00, 1'b0);
        add_beat(4'd0, 32'h1111_0003, 2'b00, 1'b1);
        add_exp(32'h1111_0000, 1'b0, 1'b0);
        add_exp(32'h1111_0001, 1'b0, 1'b0);
        add_exp(32'h1111_0002, 1'b0, 1'b0);
        add_exp(32'h1111_0003, 1'b0, 1'b1);
        run(300, -1);
        check("perr_set", protocol_err, 1);
        check("perr_beats", got_cnt, 4);

        // SLVERR on the first of two beats; the flag from before must clear
        clear_model();
        add_req(32'h5000_0008, 4'd1);
        add_beat(4'd0, 32'h2222_0000, 2'b10, 1'b0);
        add_beat(4'd0, 32'h2222_0001, 2'b00, 1'b1);
        add_exp(32'h2222_0000, 1'b1, 1'b0);
        add_exp(32'h2222_0001, 1'b0, 1'b1);
        run(300, -1);
        check("perr_cleared", protocol_err, 0);
        check("err_beats", got_cnt, 2);

        // missing RLAST on the final beat still ends the burst
        clear_model();
        add_req(32'h6000_0000, 4'd0);
        add_beat(4'd0, 32'h3333_0000, 2'b00, 1'b0);
        add_exp(32'h3333_0000, 1'b0, 1'b1);
        run(300, -1);
        check("perr_no_rlast", protocol_err, 1);

        // reset after 3 of 8 beats, then a clean request
        clear_model();
        auto_r = 1; rready_pct = 50;
        add_req(32'h7000_0000, 4'd7);
        run(300, 3);
        resetn = 1; req_valid = 0; RVALID = 0; rsp_ready = 0; ARREADY = 0;
        #1;
        check("in_reset_handshakes", {req_ready, ARVALID, RREADY, rsp_valid, protocol_err}, 5'b00000);
        @(negedge clk);
        resetn = 0;
        #1;
        check("post_reset_idle", {req_ready, ARVALID, RREADY, rsp_valid, protocol_err}, 5'b10000);
        clear_model();
        auto_r = 1;
        add_req(32'h7000_0100, 4'd7);
        run(300, -1);
        check("post_reset_beats", got_cnt, 8);

        // randomized back-to-back requests with random stalls on every channel
        clear_model();
        auto_r = 1; rand_ar = 1; rvalid_pct = 70; rready_pct = 60;
        total = 0;
        for (int n = 0; n < 30; n++) begin
            logic [3:0] l;
            l = 4'($urandom_range(0, 15));
            add_req($urandom, l);
            total += int'(l) + 1;
        end
        run(20000, -1);
        check("rand_beats", got_cnt, total);
        check("rand_perr", protocol_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
